// File: rtl/uv_pipe_elastic.sv
// Elastic valid/ready register pipeline: bubble collapsing, synchronous flush,
// occupancy count and an optional 2-entry input skid that registers in_ready.
module uv_pipe_elastic #(
   parameter int  PIPE_WIDTH = 32,
   parameter int  PIPE_STAGE = 2,
   parameter int  READY_REG  = 0,
   parameter int  RESET_DATA = 0,
   localparam int CNT_RAW    = $clog2(PIPE_STAGE + 2 * READY_REG + 1),
   localparam int CNT_W      = (CNT_RAW < 1) ? 1 : CNT_RAW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PIPE_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PIPE_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]      count
);

   if (PIPE_STAGE == 0) begin : g_pass
      logic unused_s;
      assign unused_s  = ^{clk, rst, flush};
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready;
      assign count     = {CNT_W{1'b0}};
   end else begin : g_pipe
      localparam int N = PIPE_STAGE;

      logic [N-1:0]          v_q, v_d, rdy_s, up_v_s;
      logic [PIPE_WIDTH-1:0] d_q [N];
      logic [PIPE_WIDTH-1:0] d_d [N];
      logic [PIPE_WIDTH-1:0] up_d_s [N];
      logic                  feed_valid_s;
      logic [PIPE_WIDTH-1:0] feed_data_s;
      logic                  acc_s, emit_s;
      logic [CNT_W-1:0]      cnt_q, cnt_d;

      // A stage can take new data when out_ready or any stage at or after it is empty.
      always_comb begin
         for (int k = 0; k < N; k++) begin
            rdy_s[k] = out_ready | (((~v_q) >> k) != {N{1'b0}});
         end
      end

      always_comb begin
         up_v_s[0] = feed_valid_s;
         up_d_s[0] = feed_data_s;
         for (int k = 1; k < N; k++) begin
            up_v_s[k] = v_q[k-1];
            up_d_s[k] = d_q[k-1];
         end
      end

      // Data only loads on a real upstream entry so bubbles never toggle the registers.
      always_comb begin
         v_d = v_q;
         d_d = d_q;
         for (int k = 0; k < N; k++) begin
            if (flush) begin
               v_d[k] = 1'b0;
               if (RESET_DATA != 0) d_d[k] = {PIPE_WIDTH{1'b0}};
               else                 d_d[k] = d_q[k];
            end else if (rdy_s[k]) begin
               v_d[k] = up_v_s[k];
               if (up_v_s[k]) d_d[k] = up_d_s[k];
               else           d_d[k] = d_q[k];
            end else begin
               v_d[k] = v_q[k];
               d_d[k] = d_q[k];
            end
         end
      end

      assign emit_s = v_q[N-1] & out_ready;

      always_comb begin
         if (flush) cnt_d = {CNT_W{1'b0}};
         else       cnt_d = cnt_q + CNT_W'(acc_s) - CNT_W'(emit_s);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q   <= {N{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
            for (int k = 0; k < N; k++) begin
               if (RESET_DATA != 0) d_q[k] <= {PIPE_WIDTH{1'b0}};
               else                 d_q[k] <= d_q[k];
            end
         end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
         end
      end

      assign out_valid = v_q[N-1];
      assign out_data  = d_q[N-1];
      assign count     = cnt_q;

      if (READY_REG != 0) begin : g_skid
         logic [PIPE_WIDTH-1:0] sk_q [2];
         logic [PIPE_WIDTH-1:0] sk_d [2];
         logic [1:0]            skn_q, skn_d;
         logic                  irdy_q, irdy_d;
         logic                  push_s, pop_s;

         // flush gates the flop output so nothing is taken during the flush cycle.
         assign in_ready     = irdy_q & ~flush;
         assign push_s       = in_valid & in_ready;
         assign feed_valid_s = (skn_q != 2'd0);
         assign feed_data_s  = sk_q[0];
         assign pop_s        = feed_valid_s & rdy_s[0];
         assign acc_s        = push_s;

         always_comb begin
            sk_d  = sk_q;
            skn_d = skn_q;
            if (flush) begin
               skn_d = 2'd0;
               if (RESET_DATA != 0) begin
                  sk_d[0] = {PIPE_WIDTH{1'b0}};
                  sk_d[1] = {PIPE_WIDTH{1'b0}};
               end else begin
                  sk_d = sk_q;
               end
            end else begin
               case ({push_s, pop_s})
                  2'b10: begin
                     if (skn_q == 2'd0) sk_d[0] = in_data;
                     else               sk_d[1] = in_data;
                     skn_d = skn_q + 2'd1;
                  end
                  2'b01: begin
                     sk_d[0] = sk_q[1];
                     skn_d   = skn_q - 2'd1;
                  end
                  2'b11: begin
                     if (skn_q == 2'd1) begin
                        sk_d[0] = in_data;
                     end else begin
                        sk_d[0] = sk_q[1];
                        sk_d[1] = in_data;
                     end
                  end
                  default: begin
                     sk_d  = sk_q;
                     skn_d = skn_q;
                  end
               endcase
            end
            irdy_d = flush ? 1'b0 : (skn_d != 2'd2);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               skn_q  <= 2'd0;
               irdy_q <= 1'b1;
               for (int k = 0; k < 2; k++) begin
                  if (RESET_DATA != 0) sk_q[k] <= {PIPE_WIDTH{1'b0}};
                  else                 sk_q[k] <= sk_q[k];
               end
            end else begin
               skn_q  <= skn_d;
               irdy_q <= irdy_d;
               sk_q   <= sk_d;
            end
         end
      end else begin : g_direct
         assign in_ready     = rdy_s[0] & ~flush;
         assign feed_valid_s = in_valid;
         assign feed_data_s  = in_data;
         assign acc_s        = in_valid & in_ready;
      end
   end

endmodule

// File: tb/tb_uv_pipe_elastic.sv
// Bench for uv_pipe_elastic: eight parameterisations checked every cycle against an
// ordered-entry model, plus directed scenarios with literal expectations.
module tb_uv_pipe_elastic;

   localparam int NI = 8;
   localparam int W  = 8;

   function automatic int st_f(input int g);
      case (g)
         0: return 3;
         1: return 4;
         2: return 2;
         3: return 1;
         4: return 5;
         5: return 1;
         6: return 5;
         default: return 0;
      endcase
   endfunction

   function automatic int rr_f(input int g);
      return (g == 2 || g == 4 || g == 5) ? 1 : 0;
   endfunction

   function automatic int rd_f(input int g);
      return (g == 0 || g == 4) ? 1 : 0;
   endfunction

   logic         clk = 1'b0;
   logic         rst;
   logic         fl   [NI];
   logic         iv   [NI];
   logic         ordy [NI];
   logic [W-1:0] idat [NI];
   logic         ir   [NI];
   logic         ov   [NI];
   logic [W-1:0] odat [NI];
   logic [7:0]   cnt  [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int CR = $clog2(st_f(g) + 2 * rr_f(g) + 1);
      localparam int CW = (CR < 1) ? 1 : CR;
      logic [CW-1:0] cnt_l;
      uv_pipe_elastic #(
         .PIPE_WIDTH(W), .PIPE_STAGE(st_f(g)), .READY_REG(rr_f(g)), .RESET_DATA(rd_f(g))
      ) u_dut (
         .clk(clk), .rst(rst), .flush(fl[g]),
         .in_valid(iv[g]), .in_ready(ir[g]), .in_data(idat[g]),
         .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(odat[g]),
         .count(cnt_l)
      );
      assign cnt[g] = 8'(cnt_l);
   end

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: ordered list of held entries (index 0 = oldest) with a position each;
   // position -1 means waiting in the input skid, N-1 means presented at the output.
   int           m_n   [NI];
   int           m_pos [NI][8];
   logic [W-1:0] m_dat [NI][8];
   bit           m_rdy [NI];

   function automatic bit exp_ir(input int g);
      if (st_f(g) == 0)  return ordy[g];
      if (rr_f(g) != 0)  return m_rdy[g] && !fl[g];
      return !fl[g] && (ordy[g] || m_n[g] < st_f(g));
   endfunction

   function automatic bit exp_ov(input int g);
      if (st_f(g) == 0) return iv[g];
      return (m_n[g] > 0) && (m_pos[g][0] == st_f(g) - 1);
   endfunction

   task automatic check_inst(input int g);
      logic [W-1:0] e_od;
      int           e_cnt;
      e_od  = (st_f(g) == 0) ? idat[g] : m_dat[g][0];
      e_cnt = (st_f(g) == 0) ? 0 : m_n[g];
      chk($sformatf("u%0d_in_ready", g), 32'(ir[g]), 32'(exp_ir(g)));
      chk($sformatf("u%0d_out_valid", g), 32'(ov[g]), 32'(exp_ov(g)));
      chk($sformatf("u%0d_count", g), 32'(cnt[g]), 32'(e_cnt));
      if (exp_ov(g)) chk($sformatf("u%0d_out_data", g), 32'(odat[g]), 32'(e_od));
   endtask

   task automatic step_inst(input int g);
      int n_s, lim, nsk;
      bit emit, acc;
      n_s = st_f(g);
      if (n_s == 0) return;
      emit = exp_ov(g) && ordy[g];
      acc  = iv[g] && exp_ir(g);
      if (rst) begin
         m_n[g] = 0; m_rdy[g] = 1'b1;
         return;
      end
      if (fl[g]) begin
         m_n[g] = 0; m_rdy[g] = 1'b0;
         return;
      end
      if (emit) begin
         for (int i = 1; i < m_n[g]; i++) begin
            m_pos[g][i-1] = m_pos[g][i];
            m_dat[g][i-1] = m_dat[g][i];
         end
         m_n[g]--;
      end
      // Each entry moves one place forward unless the entry ahead now sits right in front.
      lim = n_s - 1;
      for (int i = 0; i < m_n[g]; i++) begin
         if (m_pos[g][i] >= 0) begin
            m_pos[g][i] = (m_pos[g][i] + 1 < lim) ? m_pos[g][i] + 1 : lim;
            lim = m_pos[g][i] - 1;
         end else if (lim >= 0) begin
            m_pos[g][i] = 0;
            lim = -1;
         end else begin
            lim = -1;
         end
      end
      if (acc) begin
         m_pos[g][m_n[g]] = (rr_f(g) != 0) ? -1 : 0;
         m_dat[g][m_n[g]] = idat[g];
         m_n[g]++;
      end
      if (rr_f(g) != 0) begin
         nsk = 0;
         for (int i = 0; i < m_n[g]; i++) if (m_pos[g][i] < 0) nsk++;
         m_rdy[g] = (nsk < 2);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < NI; g++) begin
            check_inst(g);
            step_inst(g);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int n_acc, val, nrecv;

   initial begin
      rst = 1'b1;
      for (int g = 0; g < NI; g++) begin
         fl[g] = 1'b0; iv[g] = 1'b0; ordy[g] = 1'b1; idat[g] = 8'h00;
         m_n[g] = 0; m_rdy[g] = 1'b1;
      end
      cyc();
      chk_en = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ov", 32'(ov[0]), 32'd0);
      chk("rst_cnt", 32'(cnt[0]), 32'd0);
      chk("rst_od_cleared", 32'(odat[0]), 32'd0);
      chk("rst_skid_ready", 32'(ir[2]), 32'd1);
      cyc();

      // Back-to-back stream through 3 stages.
      for (int j = 0; j < 20; j++) begin
         iv[0]   = (j < 16);
         idat[0] = 8'(j + 1);
         @(negedge clk);
         if (j < 3) chk("t1_ov_early", 32'(ov[0]), 32'd0);
         else if (j < 19) begin
            chk("t1_ov", 32'(ov[0]), 32'd1);
            chk("t1_od", 32'(odat[0]), 32'(j - 2));
         end
         if (j < 16) chk("t1_cnt", 32'(cnt[0]), 32'((j < 3) ? j : 3));
         cyc();
      end
      iv[0] = 1'b0;

      // Stall with a full pipe, then release.
      ordy[0] = 1'b0;
      for (int j = 0; j < 3; j++) begin
         iv[0] = 1'b1; idat[0] = 8'(8'hA1 + j);
         cyc();
      end
      iv[0] = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("t2_cnt_full", 32'(cnt[0]), 32'd3);
         chk("t2_ir_stall", 32'(ir[0]), 32'd0);
         chk("t2_od_frozen", 32'(odat[0]), 32'hA1);
         cyc();
      end
      ordy[0] = 1'b1;
      @(negedge clk);
      chk("t2_ir_release", 32'(ir[0]), 32'd1);
      chk("t2_od_first", 32'(odat[0]), 32'hA1);
      cyc();
      @(negedge clk);
      chk("t2_od_second", 32'(odat[0]), 32'hA2);
      chk("t2_cnt_2", 32'(cnt[0]), 32'd2);
      cyc();
      @(negedge clk);
      chk("t2_od_third", 32'(odat[0]), 32'hA3);
      cyc();
      @(negedge clk);
      chk("t2_empty", 32'(ov[0]), 32'd0);
      cyc();

      // Flush while the output word transfers.
      ordy[0] = 1'b0;
      for (int j = 0; j < 3; j++) begin
         iv[0] = 1'b1; idat[0] = 8'(8'hB1 + j);
         cyc();
      end
      ordy[0] = 1'b1; fl[0] = 1'b1; iv[0] = 1'b1; idat[0] = 8'hCC;
      @(negedge clk);
      chk("t5_ir_flush", 32'(ir[0]), 32'd0);
      chk("t5_ov_flush", 32'(ov[0]), 32'd1);
      chk("t5_od_flush", 32'(odat[0]), 32'hB1);
      cyc();
      fl[0] = 1'b0; iv[0] = 1'b0;
      @(negedge clk);
      chk("t5_ov_after", 32'(ov[0]), 32'd0);
      chk("t5_cnt_after", 32'(cnt[0]), 32'd0);
      chk("t5_od_cleared", 32'(odat[0]), 32'd0);
      cyc();

      // Bubble collapse in 4 stages.
      ordy[1] = 1'b0;
      iv[1] = 1'b1; idat[1] = 8'hC1;
      cyc();
      iv[1] = 1'b0;
      cyc();
      cyc();
      iv[1] = 1'b1; idat[1] = 8'hC2;
      cyc();
      iv[1] = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      chk("t3_cnt", 32'(cnt[1]), 32'd2);
      chk("t3_od", 32'(odat[1]), 32'hC1);
      cyc();
      ordy[1] = 1'b1;
      @(negedge clk);
      chk("t3_od_first", 32'(odat[1]), 32'hC1);
      cyc();
      @(negedge clk);
      chk("t3_ov_second", 32'(ov[1]), 32'd1);
      chk("t3_od_second", 32'(odat[1]), 32'hC2);
      cyc();

      // Registered ready with skid: fill under stall, then drain.
      ordy[2] = 1'b0; iv[2] = 1'b1; n_acc = 0; val = 1;
      for (int j = 0; j < 8; j++) begin
         idat[2] = 8'(val);
         @(negedge clk);
         if (ir[2]) begin
            n_acc++; val++;
         end
         cyc();
      end
      iv[2] = 1'b0;
      chk("t4_accepted", 32'(n_acc), 32'd4);
      @(negedge clk);
      chk("t4_cnt", 32'(cnt[2]), 32'd4);
      chk("t4_ir_low", 32'(ir[2]), 32'd0);
      cyc();
      ordy[2] = 1'b1; nrecv = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (j == 0) chk("t4_ir_not_comb", 32'(ir[2]), 32'd0);
         if (ov[2]) begin
            chk("t4_order", 32'(odat[2]), 32'(nrecv + 1));
            nrecv++;
         end
         cyc();
      end
      chk("t4_drained", 32'(nrecv), 32'd4);

      // Pass-through instance.
      iv[7] = 1'b1; idat[7] = 8'h5A; ordy[7] = 1'b0;
      @(negedge clk);
      chk("t6_od", 32'(odat[7]), 32'h5A);
      chk("t6_ir", 32'(ir[7]), 32'd0);
      cyc();

      // Random traffic on every instance, with sporadic flush and one mid-run reset.
      for (int c = 0; c < 20000; c++) begin
         rst = (c == 10000);
         for (int g = 0; g < NI; g++) begin
            iv[g]   = ($urandom_range(3, 0) != 0);
            ordy[g] = ($urandom_range(3, 0) != 0);
            idat[g] = 8'($urandom);
            fl[g]   = ($urandom_range(99, 0) == 0);
         end
         cyc();
      end
      rst = 1'b0;
      for (int g = 0; g < NI; g++) begin
         iv[g] = 1'b0; fl[g] = 1'b0; ordy[g] = 1'b1;
      end
      for (int j = 0; j < 10; j++) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
